// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    typedef enum logic [2:0] {OP_ZERO, OP_PM, OP_P2M, OP_NM, OP_N2M} booth_op_t;

    function automatic int booth_iters(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_mult_seq_recoder.sv
// Radix-4 Booth recoder: maps {Q[1], Q[0], q_m1} onto the partial-product operation.
module booth_recoder
    import mult_pkg::*;
(
    input  logic [2:0] bits_i,
    output booth_op_t  op_o
);

    always_comb begin
        op_o = OP_ZERO;
        case (bits_i)
            3'b001, 3'b010: op_o = OP_PM;
            3'b011:         op_o = OP_P2M;
            3'b100:         op_o = OP_N2M;
            3'b101, 3'b110: op_o = OP_NM;
            default:        op_o = OP_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier with start/ready/done handshake.
// Optional overflow flag is compiled in when MULT_OVF_EN is defined.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef MULT_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int E    = WIDTH + 2;
    localparam int ITER = booth_iters(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER);

    mult_state_t        state_q, state_d;
    logic [E-1:0]       acc_q, acc_d;
    logic [E-1:0]       mplier_q, mplier_d;
    logic [E-1:0]       mcand_q, mcand_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    booth_op_t          op;
    logic [E:0]         addend;
    logic [E:0]         sum;
    logic               accept;

`ifdef MULT_OVF_EN
    logic signed_q, signed_d;
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    booth_recoder u_recoder (
        .bits_i ({mplier_q[1:0], qm1_q}),
        .op_o   (op)
    );

    assign ready   = (state_q == IDLE) || (state_q == DONE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign accept  = start & ready;

    // One extra bit on the adder keeps +/-2M from wrapping before the shift.
    always_comb begin
        addend = '0;
        case (op)
            OP_PM:   addend = {mcand_q[E-1], mcand_q};
            OP_P2M:  addend = {mcand_q, 1'b0};
            OP_NM:   addend = -{mcand_q[E-1], mcand_q};
            OP_N2M:  addend = -{mcand_q, 1'b0};
            default: addend = '0;
        endcase
    end

    assign sum = {acc_q[E-1], acc_q} + addend;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        qm1_d     = qm1_q;
        count_d   = count_q;
        product_d = product_q;
`ifdef MULT_OVF_EN
        signed_d  = signed_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mplier_d = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
                    mcand_d  = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
                    qm1_d    = 1'b0;
                    count_d  = '0;
`ifdef MULT_OVF_EN
                    signed_d = is_signed;
                    ovf_d    = 1'b0;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (count_q == LAST) begin
                    state_d   = DONE;
                    product_d = {acc_q[WIDTH-3:0], mplier_q};
`ifdef MULT_OVF_EN
                    ovf_d = signed_q
                        ? (product_d[2*WIDTH-1:WIDTH] != {WIDTH{product_d[WIDTH-1]}})
                        : (product_d[2*WIDTH-1:WIDTH] != '0);
`endif
                end else begin
                    // Arithmetic shift of {sum, Q, q_m1} right by two.
                    acc_d    = {sum[E], sum[E:2]};
                    mplier_d = {sum[1:0], mplier_q[E-1:2]};
                    qm1_d    = mplier_q[1];
                    count_d  = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
`ifdef MULT_OVF_EN
            signed_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            qm1_q     <= qm1_d;
            count_q   <= count_d;
            product_q <= product_d;
`ifdef MULT_OVF_EN
            signed_q  <= signed_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: directed handshake scenarios on a 32-bit instance
// and a random sweep over 8/16/32-bit instances against an arithmetic reference.
module tb_booth_mult_seq;

    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        isSigned;
    logic [31:0] opA, opB;
    logic        start8, start16, start32;
    logic        ready8, ready16, ready32;
    logic        busy8, busy16, busy32;
    logic        done8, done16, done32;
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic [63:0] prod32;
`ifdef MULT_OVF_EN
    logic        ovf8, ovf16, ovf32;
`endif

    int checkCount = 0;
    int passCount  = 0;

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(resetN), .start(start32), .is_signed(isSigned),
        .multiplicand(opA), .multiplier(opB),
        .ready(ready32), .busy(busy32), .done(done32), .product(prod32)
`ifdef MULT_OVF_EN
        , .ovf(ovf32)
`endif
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(resetN), .start(start16), .is_signed(isSigned),
        .multiplicand(opA[15:0]), .multiplier(opB[15:0]),
        .ready(ready16), .busy(busy16), .done(done16), .product(prod16)
`ifdef MULT_OVF_EN
        , .ovf(ovf16)
`endif
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(resetN), .start(start8), .is_signed(isSigned),
        .multiplicand(opA[7:0]), .multiplier(opB[7:0]),
        .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
`ifdef MULT_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic        o;
    } vec_t;

    vec_t vecs [5] = '{
        '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0},
        '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1},
        '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0},
        '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1},
        '{1'b1, 32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006, 1'b0}
    };

    // Mathematical value of a w-bit operand under the chosen interpretation.
    function automatic longint extVal(input int w, input logic sgn, input logic [31:0] x);
        longint v;
        v = longint'(x);
        if (sgn && x[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [63:0] refProd(input int w, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full, mask;
        full = 64'(extVal(w, sgn, a) * extVal(w, sgn, b));
        mask = (w == 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
        return full & mask;
    endfunction

`ifdef MULT_OVF_EN
    function automatic logic refOvf(input int w, input logic sgn,
                                    input logic [31:0] a, input logic [31:0] b);
        longint prod;
        logic [63:0] uprod;
        prod  = extVal(w, sgn, a) * extVal(w, sgn, b);
        uprod = 64'(prod);
        if (sgn)
            return (prod < -(longint'(1) << (w - 1))) || (prod >= (longint'(1) << (w - 1)));
        return uprod >= (64'd1 << w);
    endfunction

    function automatic logic ovfOf(input int w);
        case (w)
            8:       return ovf8;
            16:      return ovf16;
            default: return ovf32;
        endcase
    endfunction
`endif

    function automatic logic doneOf(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic [63:0] prodOf(input int w);
        case (w)
            8:       return {48'd0, prod8};
            16:      return {32'd0, prod16};
            default: return prod32;
        endcase
    endfunction

    task automatic setStart(input int w, input logic v);
        case (w)
            8:       start8  = v;
            16:      start16 = v;
            default: start32 = v;
        endcase
    endtask

    // Counts edges after the accept edge until done is seen (bounded).
    task automatic waitDone(input int w, output int lat);
        lat = 0;
        while (!doneOf(w) && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issues one request, scrambles the operand inputs after accept, returns at the done cycle.
    task automatic runOp(input int w, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output logic [63:0] p, output int lat);
        @(posedge clk); #1;
        isSigned = sgn;
        opA      = a;
        opB      = b;
        setStart(w, 1'b1);
        @(posedge clk); #1;
        setStart(w, 1'b0);
        opA      = $urandom;
        opB      = $urandom;
        isSigned = ~sgn;
        waitDone(w, lat);
        p = prodOf(w);
    endtask

    task automatic test_reset();
        resetN   = 1'b1;
        start8   = 1'b0;
        start16  = 1'b0;
        start32  = 1'b0;
        isSigned = 1'b0;
        opA      = '0;
        opB      = '0;
        #2 resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if (ready32 !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready32);
        else passCount++;
        checkCount++;
        if (busy32 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy32);
        else passCount++;
        checkCount++;
        if (done32 !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done32);
        else passCount++;
        checkCount++;
        if (prod32 !== 64'd0) $display("[TB] FAIL reset_product: got %h expected 0", prod32);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (ovf32 !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", ovf32);
        else passCount++;
`endif
        resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [63:0] p;
        int lat;
        for (int i = 0; i < 5; i++) begin
            runOp(32, vecs[i].sgn, vecs[i].a, vecs[i].b, p, lat);
            checkCount++;
            if (p !== vecs[i].p)
                $display("[TB] FAIL directed_product[%0d]: got %h expected %h", i, p, vecs[i].p);
            else passCount++;
            checkCount++;
            if (lat !== 18)
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected 18", i, lat);
            else passCount++;
`ifdef MULT_OVF_EN
            checkCount++;
            if (ovf32 !== vecs[i].o)
                $display("[TB] FAIL directed_ovf[%0d]: got %b expected %b", i, ovf32, vecs[i].o);
            else passCount++;
`endif
            @(posedge clk); #1;
            checkCount++;
            if (done32 !== 1'b0 || ready32 !== 1'b1)
                $display("[TB] FAIL directed_done_pulse[%0d]: got done=%b ready=%b expected done=0 ready=1",
                         i, done32, ready32);
            else passCount++;
        end
    endtask

    // A second request while busy must be dropped entirely.
    task automatic test_ignore_busy();
        int cyc, pulses, firstDone;
        logic [63:0] seen;
        @(posedge clk); #1;
        isSigned = 1'b0;
        opA      = 32'd5;
        opB      = 32'd5;
        start32  = 1'b1;
        @(posedge clk); #1;
        start32   = 1'b0;
        cyc       = 0;
        pulses    = 0;
        firstDone = -1;
        seen      = '0;
        repeat (4) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkCount++;
        if (busy32 !== 1'b1 || ready32 !== 1'b0)
            $display("[TB] FAIL busy_flags: got busy=%b ready=%b expected busy=1 ready=0", busy32, ready32);
        else passCount++;
        opA     = 32'd9;
        opB     = 32'd9;
        start32 = 1'b1;
        @(posedge clk); #1;
        cyc++;
        start32 = 1'b0;
        while (cyc < 45) begin
            if (done32) begin
                pulses++;
                if (firstDone < 0) firstDone = cyc;
                seen = prod32;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checkCount++;
        if (pulses !== 1) $display("[TB] FAIL busy_done_pulses: got %0d expected 1", pulses);
        else passCount++;
        checkCount++;
        if (firstDone !== 18) $display("[TB] FAIL busy_latency: got %0d expected 18", firstDone);
        else passCount++;
        checkCount++;
        if (seen !== 64'd25) $display("[TB] FAIL busy_product: got %0d expected 25", seen);
        else passCount++;
    endtask

    // A request issued in the DONE cycle starts immediately with no idle gap.
    task automatic test_back_to_back();
        logic [63:0] p;
        int lat;
        runOp(32, 1'b0, 32'd3, 32'd4, p, lat);
        checkCount++;
        if (p !== 64'd12 || ready32 !== 1'b1)
            $display("[TB] FAIL b2b_first: got product=%0d ready=%b expected product=12 ready=1", p, ready32);
        else passCount++;
        isSigned = 1'b0;
        opA      = 32'd9;
        opB      = 32'd9;
        start32  = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        opA     = $urandom;
        opB     = $urandom;
        checkCount++;
        if (busy32 !== 1'b1) $display("[TB] FAIL b2b_no_bubble: got busy=%b expected 1", busy32);
        else passCount++;
        waitDone(32, lat);
        checkCount++;
        if (lat !== 18) $display("[TB] FAIL b2b_latency: got %0d expected 18", lat);
        else passCount++;
        checkCount++;
        if (prod32 !== 64'd81) $display("[TB] FAIL b2b_product: got %0d expected 81", prod32);
        else passCount++;
    endtask

    task automatic test_reset_abort();
        logic [63:0] p;
        int lat, pulses;
        @(posedge clk); #1;
        isSigned = 1'b1;
        opA      = 32'd11;
        opB      = 32'd13;
        start32  = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        resetN = 1'b0;
        #1;
        checkCount++;
        if (ready32 !== 1'b1 || busy32 !== 1'b0 || done32 !== 1'b0)
            $display("[TB] FAIL abort_flags: got ready=%b busy=%b done=%b expected 1/0/0",
                     ready32, busy32, done32);
        else passCount++;
        checkCount++;
        if (prod32 !== 64'd0) $display("[TB] FAIL abort_product: got %h expected 0", prod32);
        else passCount++;
        @(posedge clk); #1;
        resetN = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done32) pulses++;
        end
        checkCount++;
        if (pulses !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", pulses);
        else passCount++;
        runOp(32, 1'b0, 32'd6, 32'd7, p, lat);
        checkCount++;
        if (p !== 64'd42 || lat !== 18)
            $display("[TB] FAIL abort_recover: got product=%0d latency=%0d expected 42/18", p, lat);
        else passCount++;
    endtask

    task automatic test_random_sweep();
        int widths [3] = '{8, 16, 32};
        logic [63:0] p, expP;
        logic [31:0] a, b, mask;
        int lat, w;
        for (int wi = 0; wi < 3; wi++) begin
            w    = widths[wi];
            mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 300; n++) begin
                    a = $urandom;
                    b = $urandom;
                    if (n == 0) begin a = '1; b = '1; end
                    if (n == 1) begin a = 32'd1 << (w - 1); b = 32'd1 << (w - 1); end
                    if (n == 2) a = '0;
                    a = a & mask;
                    b = b & mask;
                    runOp(w, m[0], a, b, p, lat);
                    expP = refProd(w, m[0], a, b);
                    checkCount++;
                    if (p !== expP)
                        $display("[TB] FAIL sweep_product w=%0d signed=%0d a=%h b=%h: got %h expected %h",
                                 w, m, a, b, p, expP);
                    else passCount++;
                    checkCount++;
                    if (lat !== w / 2 + 2)
                        $display("[TB] FAIL sweep_latency w=%0d: got %0d expected %0d", w, lat, w / 2 + 2);
                    else passCount++;
`ifdef MULT_OVF_EN
                    checkCount++;
                    if (ovfOf(w) !== refOvf(w, m[0], a, b))
                        $display("[TB] FAIL sweep_ovf w=%0d signed=%0d a=%h b=%h: got %b expected %b",
                                 w, m, a, b, ovfOf(w), refOvf(w, m[0], a, b));
                    else passCount++;
`endif
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_random_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
